alu_server: RTL and testbench
=============================

# alu_server

Clocked request/response front-end that sits between an RTL initiator and the combinational scientific ALU model (`alu`). It accepts one operation at a time over a valid/ready request channel. It drives the ALU operand and opcode pins and holds them stable for a fixed evaluation window, then samples result/excep/err. The sampled response goes into a small buffer drained over a valid/ready response channel, so initiators never time ALU sampling themselves.

## Interface
Parameters:
- `LATENCY`, 3: cycles operands are held before the ALU outputs are sampled; legal range 1..15.
- `DEPTH`, 2: response buffer entries; legal values 1..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle where `req_valid && req_ready`.
- `req_a` in 64: operand A, IEEE-754 double bit pattern.
- `req_b` in 64: operand B, IEEE-754 double bit pattern.
- `req_opcode` in 4: ALU opcode.
- `req_tag` in 4: opaque tag, returned unchanged with the response.
- `alu_a` out 64: registered operand A to the ALU.
- `alu_b` out 64: registered operand B to the ALU.
- `alu_opcode` out 4: registered opcode to the ALU.
- `alu_result` in 64: ALU result.
- `alu_excep` in 1: ALU exception flag.
- `alu_err` in 1: ALU error flag.
- `rsp_valid` out 1: buffer head valid.
- `rsp_ready` in 1: consumer takes the head.
- `rsp_result` out 64: buffer head result.
- `rsp_excep` out 1: buffer head exception flag.
- `rsp_err` out 1: buffer head error flag.
- `rsp_tag` out 4: buffer head tag.
- `busy` out 1: an operation is executing.

## Operation
- FSM states: IDLE, EXEC.
  - IDLE: `req_ready = !rst && (count < DEPTH)`.
  - On accept, the block latches `req_a`/`req_b`/`req_opcode` into `alu_*` and the tag into a holding register, loads `cnt = LATENCY-1`, and goes to EXEC.
  - EXEC: `req_ready=0`, `busy=1`.
    - If `cnt != 0`: decrement `cnt`.
    - If `cnt == 0`: push {`alu_result`, `alu_excep`, `alu_err`, tag} into the buffer and return to IDLE.
- Only one operation is outstanding. A buffer slot is reserved at accept time, so a push never meets a full buffer.
- `alu_*` outputs hold their last values in IDLE; they change only on accept.
- Response buffer is an in-order FIFO.
  - Pop on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - `rsp_*` data is don't-care while `rsp_valid=0`. The bench compares only when valid.
- While `rsp_valid && !rsp_ready`, head fields are stable.
- The block does no arithmetic and no interpretation of opcode or flags. ALU outputs are passed through bit-exact.
- Reset mid-operation: the in-flight op is dropped and the buffer is flushed. No response is produced for a request accepted before reset.

## Timing
- Reset values:
  - `req_ready=0` while `rst=1`.
  - `alu_a=0`, `alu_b=0`, `alu_opcode=0`.
  - `rsp_valid=0`, `rsp_result=0`, `rsp_excep=0`, `rsp_err=0`, `rsp_tag=0`.
  - `busy=0`, FSM in IDLE, count 0.
- Accept at edge T:
  - `alu_*` are new after T.
  - Sample occurs at edge T+LATENCY.
  - `rsp_valid` is high after T+LATENCY when the buffer was previously empty.
- `busy` is high from after T until after T+LATENCY.
- `req_ready` is low during EXEC, so back-to-back accepts are spaced LATENCY+1 edges apart.
- The push at T+LATENCY and the return to IDLE happen on the same edge. `req_ready` can be high in the cycle after the edge.
- DEPTH full: `req_ready` stays low until a pop. A pop at edge P makes `req_ready` high after P.

## Structure
- Package `alu_server_pkg`:
  - `DATA_W=64`, `OPC_W=4`, `TAG_W=4`.
  - FSM state typedef (IDLE, EXEC).
  - Response struct {result, excep, err, tag}.
- Sub-module `alu_rsp_fifo`: parameterised DEPTH, synchronous flush on `rst`, outputs count.
- The `alu` model is instantiated in the bench, not inside this block.

## Test plan
- Single op: a=16.0 (0x4030000000000000), b=2.0 (0x4000000000000000), opcode 0, tag 5, LATENCY=3. Required response:
  - `rsp_valid` exactly 3 edges after accept.
  - `rsp_result=0x4032000000000000` (18.0), tag 5, excep=0, err=0.
- Opcode sweep: opcodes 0..15 with a=16.0, b=2.0 and tags 0..15, `rsp_ready=1`. Required response:
  - 16 responses in order.
  - Each result/excep/err equals the ALU model output for that opcode.
  - Accept spacing is exactly 4 cycles.
- Backpressure, DEPTH=2: `rsp_ready=0`, issue 3 requests. Required response:
  - Two accepted; `req_ready` stays low afterwards.
  - Raise `rsp_ready` for 1 cycle: tag 0 pops, the third request is accepted, tag 1 head is unchanged.
- Simultaneous push/pop: `rsp_ready` held high while ops complete back-to-back. Required response: count never exceeds 1, no response lost or duplicated.
- Flag pass-through: opcode 3, b=0.0. Required response: `rsp_excep` and `rsp_err` equal the model's outputs bit-exact.
- Reset mid-op: assert `rst` at cycle 2 of EXEC with one response buffered. Required response:
  - After reset: `rsp_valid=0`, `busy=0`, `alu_a=0`.
  - No stale response appears later.
  - A fresh request completes normally.

Source files
------------

// File: rtl/alu_server_pkg.sv
// alu_server_pkg: shared widths, FSM state encoding and the response record
// used by the ALU request/response front-end and its response buffer.
package alu_server_pkg;

    localparam int DATA_W = 64;
    localparam int OPC_W  = 4;
    localparam int TAG_W  = 4;

    // Two-state sequencer; kept as plain logic constants so older tools and
    // waveform scripts that expect raw encodings keep working.
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t EXEC = 1'b1;

    // One buffered ALU response.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              excep;
        logic              err;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: small in-order response buffer.
//   clk, rst         : clock, synchronous active-high flush
//   push, push_data  : write one response (caller guarantees a free slot)
//   pop              : consume head; ignored when empty
//   head, head_valid : oldest entry and its presence
//   count            : current occupancy (0..DEPTH)
module alu_rsp_fifo
    import alu_server_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rsp_t             push_data,
    input  logic             pop,
    output rsp_t             head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    // Storage is cleared on flush so the head reads all-zero out of reset.
    assign head       = mem[rd_ptr];

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            // Simultaneous push and pop leave occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_server.sv
// alu_server: clocked front-end for a combinational ALU.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/ready, req_a/b/opcode/tag : one-at-a-time request channel
//   alu_a/b/opcode                 : registered operands held across the window
//   alu_result/excep/err           : ALU outputs, sampled LATENCY edges after accept
//   rsp_valid/ready, rsp_result/excep/err/tag : buffered response channel
//   busy                           : an operation is in its evaluation window
module alu_server
    import alu_server_pkg::*;
#(
    parameter int LATENCY = 3,   // 1..15
    parameter int DEPTH   = 2    // 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_excep,
    input  logic              alu_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_excep,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             push;
    rsp_t             push_data;
    rsp_t             head;
    logic [CNT_W-1:0] count;

    // Occupancy check at accept reserves the slot the eventual push uses,
    // since only one op is ever in flight.
    assign req_ready = (state == IDLE) && !rst && (count < CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = (state == EXEC) && (cnt == '0);
    assign busy      = (state == EXEC);

    always_comb begin
        push_data        = '0;
        push_data.result = alu_result;
        push_data.excep  = alu_excep;
        push_data.err    = alu_err;
        push_data.tag    = tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tag_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= req_a;
                        alu_b      <= req_b;
                        alu_opcode <= req_opcode;
                        tag_q      <= req_tag;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (rsp_ready),
        .head       (head),
        .head_valid (rsp_valid),
        .count      (count)
    );

    assign rsp_result = head.result;
    assign rsp_excep  = head.excep;
    assign rsp_err    = head.err;
    assign rsp_tag    = head.tag;

endmodule

// File: tb/tb_alu_server.sv
module tb_alu_server;
    import alu_server_pkg::*;

    localparam logic [63:0] F16 = 64'h4030000000000000;
    localparam logic [63:0] F2  = 64'h4000000000000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_opcode, req_tag;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_excep, alu_err;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_excep, rsp_err;
    logic [3:0]  rsp_tag;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    rsp_t exp_q[$];
    rsp_t got, e;
    bit   track_max = 0;
    int   max_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_server #(.LATENCY(3), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_excep(alu_excep), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_excep(rsp_excep), .rsp_err(rsp_err),
        .rsp_tag(rsp_tag), .busy(busy)
    );

    // Behavioural ALU stand-in driven by the DUT's registered operands.
    real ra, rb;
    always_comb begin
        alu_result = '0;
        alu_excep  = 1'b0;
        alu_err    = 1'b0;
        ra = $bitstoreal(alu_a);
        rb = $bitstoreal(alu_b);
        case (alu_opcode)
            4'd0:  alu_result = $realtobits(ra + rb);
            4'd1:  alu_result = $realtobits(ra - rb);
            4'd2:  alu_result = $realtobits(ra * rb);
            4'd3:  if (alu_b[62:0] == 63'd0) begin
                       alu_result = 64'h7FF0000000000000;
                       alu_excep  = 1'b1;
                   end else alu_result = $realtobits(ra / rb);
            4'd4:  alu_result = alu_a;
            4'd5:  alu_result = alu_b;
            4'd6:  alu_result = alu_a ^ alu_b;
            4'd7:  alu_result = alu_a & alu_b;
            4'd8:  alu_result = alu_a | alu_b;
            4'd9:  alu_result = ~alu_a;
            4'd10: alu_result = {~alu_a[63], alu_a[62:0]};
            4'd11: alu_result = {alu_a[31:0], alu_b[63:32]};
            default: alu_err = 1'b1;
        endcase
    end

    function automatic rsp_t mk(input logic [63:0] r, input logic x, input logic er, input logic [3:0] t);
        rsp_t v;
        v.result = r; v.excep = x; v.err = er; v.tag = t;
        return v;
    endfunction

    // Hand-computed responses for a=16.0, b=2.0.
    function automatic rsp_t exp16(input logic [3:0] op, input logic [3:0] t);
        case (op)
            4'd0:  return mk(64'h4032000000000000, 1'b0, 1'b0, t);
            4'd1:  return mk(64'h402C000000000000, 1'b0, 1'b0, t);
            4'd2:  return mk(64'h4040000000000000, 1'b0, 1'b0, t);
            4'd3:  return mk(64'h4020000000000000, 1'b0, 1'b0, t);
            4'd4:  return mk(64'h4030000000000000, 1'b0, 1'b0, t);
            4'd5:  return mk(64'h4000000000000000, 1'b0, 1'b0, t);
            4'd6:  return mk(64'h0030000000000000, 1'b0, 1'b0, t);
            4'd7:  return mk(64'h4000000000000000, 1'b0, 1'b0, t);
            4'd8:  return mk(64'h4030000000000000, 1'b0, 1'b0, t);
            4'd9:  return mk(64'hBFCFFFFFFFFFFFFF, 1'b0, 1'b0, t);
            4'd10: return mk(64'hC030000000000000, 1'b0, 1'b0, t);
            4'd11: return mk(64'h0000000040000000, 1'b0, 1'b0, t);
            default: return mk(64'h0, 1'b0, 1'b1, t);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares whenever a response handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            got.result = rsp_result; got.excep = rsp_excep; got.err = rsp_err; got.tag = rsp_tag;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp actual tag=%0d result=%h required none", rsp_tag, rsp_result);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL rsp actual tag=%0d res=%h x=%b e=%b required tag=%0d res=%h x=%b e=%b",
                             got.tag, got.result, got.excep, got.err, e.tag, e.result, e.excep, e.err);
                end
            end
        end
        if (track_max && int'(dut.count) > max_count) max_count = int'(dut.count);
    end

    // Drive a request, wait (bounded) for acceptance; t = edge number of accept.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [3:0] tg, input rsp_t ex, output int t);
        int n = 0;
        req_valid = 1'b1; req_a = a; req_b = b; req_opcode = op; req_tag = tg;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept tag=%0d", tg);
            req_valid = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        exp_q.push_back(ex);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        #1;
    endtask

    initial begin
        int t, prev, lat, seen;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_opcode = '0; req_tag = '0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_result, rsp_excep, rsp_err, rsp_tag}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // Single op and latency
        issue(F16, F2, 4'd0, 4'd5, exp16(4'd0, 4'd5), t);
        chk("single_alu_a", alu_a, F16);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", lat, 3);
        rsp_ready = 1'b1;
        wait_drain();

        // Opcode sweep with accept spacing
        track_max = 1; max_count = 0; prev = 0;
        for (int op = 0; op < 16; op++) begin
            issue(F16, F2, 4'(op), 4'(op), exp16(4'(op), 4'(op)), t);
            if (op > 0) chk("sweep_spacing", t - prev, 4);
            prev = t;
        end
        wait_drain();

        // Push and pop on the same edge
        rsp_ready = 1'b0;
        issue(F16, F2, 4'd1, 4'd3, exp16(4'd1, 4'd3), t);
        repeat (5) @(posedge clk); #1;
        issue(F16, F2, 4'd2, 4'd4, exp16(4'd2, 4'd4), t);
        repeat (2) @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("pushpop_count", dut.count, 1);
        wait_drain();
        track_max = 0;
        chk("pushpop_max_count", max_count, 1);

        // Backpressure with DEPTH=2
        rsp_ready = 1'b0;
        issue(F16, F2, 4'd0, 4'd0, exp16(4'd0, 4'd0), t);
        issue(F16, F2, 4'd1, 4'd1, exp16(4'd1, 4'd1), t);
        req_valid = 1'b1; req_a = F16; req_b = F2; req_opcode = 4'd2; req_tag = 4'd2;
        seen = 0;
        repeat (10) @(negedge clk) if (req_ready) seen = 1;
        chk("bp_req_ready_low", seen, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_req_ready_after_pop", req_ready, 1);
        chk("bp_head_tag", rsp_tag, 1);
        @(posedge clk); #1;
        exp_q.push_back(exp16(4'd2, 4'd2));
        req_valid = 1'b0;
        chk("bp_third_busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("bp_head_stable", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd1, 64'h402C000000000000});
        rsp_ready = 1'b1;
        wait_drain();

        // Flag pass-through
        issue(F16, 64'h0, 4'd3, 4'd9, mk(64'h7FF0000000000000, 1'b1, 1'b0, 4'd9), t);
        issue(F16, 64'h0, 4'd12, 4'd10, mk(64'h0, 1'b0, 1'b1, 4'd10), t);
        wait_drain();

        // Reset mid-op with one response buffered
        rsp_ready = 1'b0;
        issue(F16, F2, 4'd0, 4'd6, exp16(4'd0, 4'd6), t);
        repeat (5) @(posedge clk); #1;
        issue(F2, F16, 4'd4, 4'd7, exp16(4'd4, 4'd7), t);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_alu_a", alu_a, 0);
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) @(negedge clk) if (rsp_valid) seen = 1;
        chk("midrst_no_stale", seen, 0);
        @(posedge clk); #1;
        issue(F16, F2, 4'd2, 4'd11, exp16(4'd2, 4'd11), t);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
